dispatch_ctrl: RTL and testbench

Sits between the decode stage and the three reservation stations (ALU, LSU, BRU) and the ROB of the out-of-order core. It holds one decoded instruction and classifies it by opcode. Dispatch to the target station happens only when that station and the ROB both have free slots, tracked by credit counters. It allocates a wrapping ROB tag per dispatched instruction and supports a full pipeline flush.

---
 rtl/dispatch_ctrl_if.sv | 48 ++++
 rtl/dispatch_ctrl.sv | 164 ++++++++++++++++
 tb/tb_dispatch_ctrl.sv | 381 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dispatch_ctrl_if.sv
// Decode-to-dispatch bus: decoded instruction handshake, consumer credit returns
// and the dispatched instruction as seen by the reservation stations / ROB.
interface dispatch_ctrl_if #(
    parameter int TW = 4
);
    logic          valid_in;
    logic          ready_in;
    logic [31:0]   pc_in;
    logic [31:0]   imm_in;
    logic [4:0]    rs1_in;
    logic [4:0]    rs2_in;
    logic [4:0]    rd_in;
    logic [3:0]    alu_op_in;
    logic [6:0]    opcode_in;
    logic          flush;
    logic          alu_free;
    logic          lsu_free;
    logic          bru_free;
    logic          rob_free;
    logic          dispatch_valid;
    logic [2:0]    dispatch_target;
    logic [31:0]   pc_out;
    logic [31:0]   imm_out;
    logic [4:0]    rs1_out;
    logic [4:0]    rs2_out;
    logic [4:0]    rd_out;
    logic [3:0]    alu_op_out;
    logic [6:0]    opcode_out;
    logic [TW-1:0] rob_tag;
    logic          illegal;
    logic [31:0]   stall_count;

    modport master (
        output valid_in, pc_in, imm_in, rs1_in, rs2_in, rd_in, alu_op_in, opcode_in,
        output flush, alu_free, lsu_free, bru_free, rob_free,
        input  ready_in, dispatch_valid, dispatch_target, pc_out, imm_out,
        input  rs1_out, rs2_out, rd_out, alu_op_out, opcode_out, rob_tag,
        input  illegal, stall_count
    );

    modport slave (
        input  valid_in, pc_in, imm_in, rs1_in, rs2_in, rd_in, alu_op_in, opcode_in,
        input  flush, alu_free, lsu_free, bru_free, rob_free,
        output ready_in, dispatch_valid, dispatch_target, pc_out, imm_out,
        output rs1_out, rs2_out, rd_out, alu_op_out, opcode_out, rob_tag,
        output illegal, stall_count
    );
endinterface

// File: rtl/dispatch_ctrl.sv
// Single-entry dispatch stage: classifies a decoded instruction and issues it to
// ALU/LSU/BRU once the target station and the ROB both hold a credit.
module dispatch_ctrl #(
    parameter int ALU_RS_DEPTH = 8,
    parameter int LSU_RS_DEPTH = 4,
    parameter int BRU_RS_DEPTH = 4,
    parameter int ROB_DEPTH    = 16,
    localparam int TW          = $clog2(ROB_DEPTH)
) (
    input logic             clk,
    input logic             reset,
    dispatch_ctrl_if.slave  bus
);
    localparam int MAX_RS = (ALU_RS_DEPTH > LSU_RS_DEPTH)
                          ? ((ALU_RS_DEPTH > BRU_RS_DEPTH) ? ALU_RS_DEPTH : BRU_RS_DEPTH)
                          : ((LSU_RS_DEPTH > BRU_RS_DEPTH) ? LSU_RS_DEPTH : BRU_RS_DEPTH);
    localparam int MAX_D  = (MAX_RS > ROB_DEPTH) ? MAX_RS : ROB_DEPTH;
    localparam int CW     = $clog2(MAX_D + 1);

    localparam logic [CW-1:0] ALU_D = CW'(ALU_RS_DEPTH);
    localparam logic [CW-1:0] LSU_D = CW'(LSU_RS_DEPTH);
    localparam logic [CW-1:0] BRU_D = CW'(BRU_RS_DEPTH);
    localparam logic [CW-1:0] ROB_D = CW'(ROB_DEPTH);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] alu_cr, lsu_cr, bru_cr, rob_cr;
    logic [TW-1:0] tail;
    logic          illegal_q;
    logic [31:0]   stall_q;

    logic [2:0]    tgt_p0;
    logic [31:0]   pc_p0, imm_p0;
    logic [4:0]    rs1_p0, rs2_p0, rd_p0;
    logic [3:0]    alu_op_p0;
    logic [6:0]    opcode_p0;

    logic [2:0]    cls;
    logic          credit_ok, can_go, disp, ready;
    logic          accept, accept_ok, accept_bad;

    // One-hot {BRU, LSU, ALU}; zero means the opcode cannot be dispatched.
    function automatic logic [2:0] classify(input logic [6:0] op);
        case (op)
            7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111: return 3'b001;
            7'b0000011, 7'b0100011:                         return 3'b010;
            7'b1100011, 7'b1101111, 7'b1100111:             return 3'b100;
            default:                                        return 3'b000;
        endcase
    endfunction

    // A same-cycle take and return cancel; a return at full credit is dropped.
    function automatic logic [CW-1:0] credit_next(input logic [CW-1:0] cr,
                                                  input logic          dec,
                                                  input logic          free,
                                                  input logic [CW-1:0] depth);
        logic inc;
        inc = free && ((cr != depth) || dec);
        return cr + CW'(inc) - CW'(dec);
    endfunction

    assign cls       = classify(bus.opcode_in);
    assign credit_ok = (tgt_p0[0] && (alu_cr != '0)) ||
                       (tgt_p0[1] && (lsu_cr != '0)) ||
                       (tgt_p0[2] && (bru_cr != '0));
    assign can_go    = (state == FULL) && credit_ok && (rob_cr != '0);

    always_comb begin
        ready = 1'b0;
        disp  = 1'b0;
        case (state)
            EMPTY: ready = !bus.flush;
            FULL: begin
                disp  = can_go && !bus.flush;
                ready = disp;
            end
            default: ;
        endcase
    end

    assign accept     = bus.valid_in && ready;
    assign accept_ok  = accept && (cls != 3'b000);
    assign accept_bad = accept && (cls == 3'b000);

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: if (accept_ok) state_nxt = FULL;
            FULL:  if (disp && !accept_ok) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
        if (bus.flush) state_nxt = EMPTY;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= EMPTY;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_cr    <= ALU_D;
            lsu_cr    <= LSU_D;
            bru_cr    <= BRU_D;
            rob_cr    <= ROB_D;
            tail      <= '0;
            illegal_q <= 1'b0;
            stall_q   <= '0;
        end else if (bus.flush) begin
            alu_cr    <= ALU_D;
            lsu_cr    <= LSU_D;
            bru_cr    <= BRU_D;
            rob_cr    <= ROB_D;
            tail      <= '0;
            illegal_q <= 1'b0;
        end else begin
            alu_cr    <= credit_next(alu_cr, disp && tgt_p0[0], bus.alu_free, ALU_D);
            lsu_cr    <= credit_next(lsu_cr, disp && tgt_p0[1], bus.lsu_free, LSU_D);
            bru_cr    <= credit_next(bru_cr, disp && tgt_p0[2], bus.bru_free, BRU_D);
            rob_cr    <= credit_next(rob_cr, disp,              bus.rob_free, ROB_D);
            illegal_q <= accept_bad;
            if (disp)                      tail    <= tail + 1'b1;
            if (state == FULL && !can_go)  stall_q <= stall_q + 32'd1;
        end
    end

    // Hold register: accept_ok is never set during a flush since ready is low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tgt_p0    <= '0;
            pc_p0     <= '0;
            imm_p0    <= '0;
            rs1_p0    <= '0;
            rs2_p0    <= '0;
            rd_p0     <= '0;
            alu_op_p0 <= '0;
            opcode_p0 <= '0;
        end else if (accept_ok) begin
            tgt_p0    <= cls;
            pc_p0     <= bus.pc_in;
            imm_p0    <= bus.imm_in;
            rs1_p0    <= bus.rs1_in;
            rs2_p0    <= bus.rs2_in;
            rd_p0     <= bus.rd_in;
            alu_op_p0 <= bus.alu_op_in;
            opcode_p0 <= bus.opcode_in;
        end
    end

    assign bus.ready_in        = ready;
    assign bus.dispatch_valid  = disp;
    assign bus.dispatch_target = disp ? tgt_p0 : 3'b000;
    assign bus.pc_out          = pc_p0;
    assign bus.imm_out         = imm_p0;
    assign bus.rs1_out         = rs1_p0;
    assign bus.rs2_out         = rs2_p0;
    assign bus.rd_out          = rd_p0;
    assign bus.alu_op_out      = alu_op_p0;
    assign bus.opcode_out      = opcode_p0;
    assign bus.rob_tag         = tail;
    assign bus.illegal         = illegal_q;
    assign bus.stall_count     = stall_q;
endmodule

// File: tb/tb_dispatch_ctrl.sv
// Bench for dispatch_ctrl: opcode table, credit/tag reference model with an
// in-order scoreboard, and hand-written flush / stall / wrap sequences.
module tb_dispatch_ctrl;
    localparam logic [6:0] OP_ADD  = 7'b0110011;
    localparam logic [6:0] OP_ADDI = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_BAD  = 7'b1111111;

    logic clk = 1'b0;
    logic reset;

    dispatch_ctrl_if #(.TW(4)) bus();

    dispatch_ctrl #(
        .ALU_RS_DEPTH(8), .LSU_RS_DEPTH(4), .BRU_RS_DEPTH(4), .ROB_DEPTH(16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [6:0]  op;
        logic [2:0]  tgt;
        logic [3:0]  tag;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [6:0] op;
        logic [2:0] tgt;
        logic       ill;
    } vec_t;

    // reference model state
    logic        m_full;
    int          m_ti;
    int          m_cr[3];
    int          m_rob;
    logic [3:0]  m_tag;
    logic [31:0] m_stall;
    logic        m_ill;
    int          acc_cnt;

    function automatic logic [2:0] classify(input logic [6:0] op);
        case (op)
            7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111: return 3'b001;
            7'b0000011, 7'b0100011:                         return 3'b010;
            7'b1100011, 7'b1101111, 7'b1100111:             return 3'b100;
            default:                                        return 3'b000;
        endcase
    endfunction

    function automatic int depth_of(input int k);
        return (k == 0) ? 8 : 4;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear(input logic keep_stall);
        m_full  = 1'b0;
        m_ti    = 0;
        m_cr[0] = 8;
        m_cr[1] = 4;
        m_cr[2] = 4;
        m_rob   = 16;
        m_tag   = 4'd0;
        m_ill   = 1'b0;
        acc_cnt = 0;
        if (!keep_stall) m_stall = 32'd0;
        sb.delete();
    endtask

    // Monitor: compares every cycle against the model, then advances the model
    // with the inputs that will be seen at the coming rising edge.
    always @(negedge clk) begin
        logic       exp_go, exp_ready, acc, dec, inc;
        logic [2:0] cls, frees;
        exp_t       e;
        if (reset) begin
            chk("rst_dispatch_valid", 32'(bus.dispatch_valid), 32'd0);
            chk("rst_target",         32'(bus.dispatch_target), 32'd0);
            chk("rst_rob_tag",        32'(bus.rob_tag), 32'd0);
            chk("rst_stall_count",    bus.stall_count, 32'd0);
            chk("rst_illegal",        32'(bus.illegal), 32'd0);
            chk("rst_pc_out",         bus.pc_out, 32'd0);
            model_clear(1'b0);
        end else begin
            exp_go    = m_full && (m_cr[m_ti] > 0) && (m_rob > 0) && !bus.flush;
            exp_ready = !bus.flush && (!m_full || exp_go);
            chk("dispatch_valid", 32'(bus.dispatch_valid), 32'(exp_go));
            chk("ready_in",       32'(bus.ready_in), 32'(exp_ready));
            chk("rob_tag",        32'(bus.rob_tag), 32'(m_tag));
            chk("stall_count",    bus.stall_count, m_stall);
            chk("illegal",        32'(bus.illegal), 32'(m_ill));
            if (bus.dispatch_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_underflow: dispatch with nothing expected at %0t", $time);
                end else begin
                    e = sb.pop_front();
                    chk("sb_pc",     bus.pc_out, e.pc);
                    chk("sb_imm",    bus.imm_out, e.imm);
                    chk("sb_rd",     32'(bus.rd_out), 32'(e.rd));
                    chk("sb_opcode", 32'(bus.opcode_out), 32'(e.op));
                    chk("sb_target", 32'(bus.dispatch_target), 32'(e.tgt));
                    chk("sb_tag",    32'(bus.rob_tag), 32'(e.tag));
                end
            end
            if (bus.flush) begin
                model_clear(1'b1);
            end else begin
                frees = {bus.bru_free, bus.lsu_free, bus.alu_free};
                for (int k = 0; k < 3; k++) begin
                    dec = exp_go && (m_ti == k);
                    inc = frees[k] && ((m_cr[k] < depth_of(k)) || dec);
                    m_cr[k] = m_cr[k] + int'(inc) - int'(dec);
                end
                inc   = bus.rob_free && ((m_rob < 16) || exp_go);
                m_rob = m_rob + int'(inc) - int'(exp_go);
                if (exp_go) m_tag = m_tag + 4'd1;
                if (m_full && !exp_go) m_stall = m_stall + 32'd1;
                acc   = bus.valid_in && exp_ready;
                cls   = classify(bus.opcode_in);
                m_ill = acc && (cls == 3'b000);
                if (acc && cls != 3'b000) begin
                    m_full = 1'b1;
                    m_ti   = cls[0] ? 0 : (cls[1] ? 1 : 2);
                    e.pc   = bus.pc_in;
                    e.imm  = bus.imm_in;
                    e.rd   = bus.rd_in;
                    e.op   = bus.opcode_in;
                    e.tgt  = cls;
                    e.tag  = 4'(acc_cnt);
                    sb.push_back(e);
                    acc_cnt++;
                end else if (exp_go) begin
                    m_full = 1'b0;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_inputs();
        bus.valid_in  = 1'b0;
        bus.pc_in     = '0;
        bus.imm_in    = '0;
        bus.rs1_in    = '0;
        bus.rs2_in    = '0;
        bus.rd_in     = '0;
        bus.alu_op_in = '0;
        bus.opcode_in = '0;
        bus.flush     = 1'b0;
        bus.alu_free  = 1'b0;
        bus.lsu_free  = 1'b0;
        bus.bru_free  = 1'b0;
        bus.rob_free  = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        tick(2);
        reset = 1'b0;
    endtask

    task automatic drive(input logic [6:0] op, input logic [31:0] pc);
        bus.valid_in  = 1'b1;
        bus.opcode_in = op;
        bus.pc_in     = pc;
        bus.imm_in    = ~pc;
        bus.rs1_in    = pc[6:2];
        bus.rs2_in    = pc[11:7];
        bus.rd_in     = pc[8:4];
        bus.alu_op_in = pc[5:2];
    endtask

    // Holds the instruction until it is accepted; bounded wait.
    task automatic send(input logic [6:0] op, input logic [31:0] pc);
        int n;
        n = 0;
        drive(op, pc);
        @(negedge clk);
        while (!bus.ready_in && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!bus.ready_in) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: ready_in stayed 0 for pc %0h", pc);
        end
        @(posedge clk);
        #1;
        bus.valid_in = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[12];
        vecs[0]  = '{7'b0110011, 3'b001, 1'b0};
        vecs[1]  = '{7'b0010011, 3'b001, 1'b0};
        vecs[2]  = '{7'b0110111, 3'b001, 1'b0};
        vecs[3]  = '{7'b0010111, 3'b001, 1'b0};
        vecs[4]  = '{7'b0000011, 3'b010, 1'b0};
        vecs[5]  = '{7'b0100011, 3'b010, 1'b0};
        vecs[6]  = '{7'b1100011, 3'b100, 1'b0};
        vecs[7]  = '{7'b1101111, 3'b100, 1'b0};
        vecs[8]  = '{7'b1100111, 3'b100, 1'b0};
        vecs[9]  = '{7'b1111111, 3'b000, 1'b1};
        vecs[10] = '{7'b0000000, 3'b000, 1'b1};
        vecs[11] = '{7'b0001111, 3'b000, 1'b1};

        reset = 1'b1;
        clear_inputs();
        do_reset();

        // opcode classification table
        for (int i = 0; i < 12; i++) begin
            do_reset();
            drive(vecs[i].op, 32'h1000 + 32'(i) * 4);
            tick(1);
            bus.valid_in = 1'b0;
            @(negedge clk);
            chk("tbl_target",  32'(bus.dispatch_target), 32'(vecs[i].tgt));
            chk("tbl_illegal", 32'(bus.illegal), 32'(vecs[i].ill));
            chk("tbl_ready",   32'(bus.ready_in), 32'(!vecs[i].ill ? 1'b1 : 1'b1));
            tick(1);
        end

        // single ADDI
        do_reset();
        send(OP_ADDI, 32'h100);
        @(negedge clk);
        chk("addi_dv",     32'(bus.dispatch_valid), 32'd1);
        chk("addi_target", 32'(bus.dispatch_target), 32'b001);
        chk("addi_tag",    32'(bus.rob_tag), 32'd0);
        chk("addi_pc",     bus.pc_out, 32'h100);
        tick(1);

        // five loads against four LSU credits
        do_reset();
        for (int i = 0; i < 5; i++) send(OP_LW, 32'h200 + 32'(i) * 4);
        @(negedge clk);
        chk("lw5_ready", 32'(bus.ready_in), 32'd0);
        chk("lw5_stall0", bus.stall_count, 32'd0);
        tick(2);
        @(negedge clk);
        chk("lw5_stall2", bus.stall_count, 32'd2);
        tick(1);
        bus.lsu_free = 1'b1;
        tick(1);
        bus.lsu_free = 1'b0;
        @(negedge clk);
        chk("lw5_dv",  32'(bus.dispatch_valid), 32'd1);
        chk("lw5_tag", 32'(bus.rob_tag), 32'd4);
        chk("lw5_pc",  bus.pc_out, 32'h210);
        tick(1);

        // illegal opcode
        do_reset();
        drive(OP_BAD, 32'h300);
        tick(1);
        bus.valid_in = 1'b0;
        @(negedge clk);
        chk("ill_pulse", 32'(bus.illegal), 32'd1);
        chk("ill_dv",    32'(bus.dispatch_valid), 32'd0);
        chk("ill_ready", 32'(bus.ready_in), 32'd1);
        tick(1);
        @(negedge clk);
        chk("ill_clear", 32'(bus.illegal), 32'd0);
        tick(1);
        send(OP_ADDI, 32'h304);
        tick(2);

        // 17 ALU ops: ALU credit exhaustion, then ROB exhaustion and tag wrap
        do_reset();
        for (int i = 0; i < 9; i++) send(OP_ADD, 32'h400 + 32'(i) * 4);
        tick(2);
        @(negedge clk);
        chk("alu9_blocked", 32'(bus.dispatch_valid), 32'd0);
        tick(1);
        bus.alu_free = 1'b1;
        for (int i = 9; i < 17; i++) send(OP_ADD, 32'h400 + 32'(i) * 4);
        @(negedge clk);
        chk("rob_blocked", 32'(bus.dispatch_valid), 32'd0);
        tick(1);
        bus.rob_free = 1'b1;
        tick(1);
        bus.rob_free = 1'b0;
        bus.alu_free = 1'b0;
        @(negedge clk);
        chk("wrap_dv",  32'(bus.dispatch_valid), 32'd1);
        chk("wrap_tag", 32'(bus.rob_tag), 32'd0);
        tick(2);

        // flush while a BRU op is blocked, with a bru_free in the same cycle
        do_reset();
        for (int i = 0; i < 5; i++) send(OP_JAL, 32'h600 + 32'(i) * 4);
        @(negedge clk);
        chk("bru_blocked", 32'(bus.dispatch_valid), 32'd0);
        tick(1);
        bus.bru_free = 1'b1;
        bus.flush    = 1'b1;
        @(negedge clk);
        chk("flush_dv",    32'(bus.dispatch_valid), 32'd0);
        chk("flush_ready", 32'(bus.ready_in), 32'd0);
        tick(1);
        bus.bru_free = 1'b0;
        bus.flush    = 1'b0;
        @(negedge clk);
        chk("post_flush_ready", 32'(bus.ready_in), 32'd1);
        chk("post_flush_tag",   32'(bus.rob_tag), 32'd0);
        chk("post_flush_dv",    32'(bus.dispatch_valid), 32'd0);
        tick(1);
        for (int i = 0; i < 4; i++) send(OP_JAL, 32'h700 + 32'(i) * 4);
        for (int i = 0; i < 4; i++) send(OP_LW,  32'h740 + 32'(i) * 4);
        for (int i = 0; i < 8; i++) send(OP_ADD, 32'h780 + 32'(i) * 4);
        tick(2);

        // dispatch and alu_free in the same cycle at ALU credit 1
        do_reset();
        for (int i = 0; i < 7; i++) send(OP_ADDI, 32'h800 + 32'(i) * 4);
        tick(1);
        send(OP_ADDI, 32'h840);
        bus.alu_free = 1'b1;
        send(OP_ADDI, 32'h844);
        bus.alu_free = 1'b0;
        @(negedge clk);
        chk("net0_dv",    32'(bus.dispatch_valid), 32'd1);
        chk("net0_pc",    bus.pc_out, 32'h844);
        chk("net0_stall", bus.stall_count, 32'd0);
        tick(2);

        // reset while a blocked instruction is held
        do_reset();
        for (int i = 0; i < 5; i++) send(OP_LW, 32'h900 + 32'(i) * 4);
        tick(2);
        do_reset();
        @(negedge clk);
        chk("rst_mid_ready", 32'(bus.ready_in), 32'd1);
        chk("rst_mid_stall", bus.stall_count, 32'd0);
        tick(1);
        send(OP_ADDI, 32'hA00);
        @(negedge clk);
        chk("rst_mid_tag", 32'(bus.rob_tag), 32'd0);
        tick(3);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
